// File: rtl/wb_pipe_master.sv
// Wishbone B4 pipelined initiator.
// Turns a valid/ready request stream into pipelined Wishbone transfers and
// returns one in-order response per accepted request, with up to
// MAX_OUTSTANDING transfers issued but not yet terminated.
module wb_pipe_master #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  // request stream
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  // response stream
  output logic                rsp_valid_o,
  output logic                rsp_we_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                busy_o,
  // Wishbone master side
  output logic                cyc_o,
  output logic                stb_o,
  output logic                lock_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W/8-1:0] sel_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ack_i,
  input  logic                err_i,
  input  logic                rty_i,
  input  logic                stall_i
);

  localparam int SEL_W = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  // Issue register
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cyc_q, cyc_d;

  // Outstanding count and we-tag FIFO (one tag bit per in-flight transfer)
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;

  logic issue;
  logic term;
  logic accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode: issue, termination and credit-checked acceptance
  always_comb begin
    issue = stb_q & ~stall_i;
    // A termination only counts when something is actually outstanding;
    // stray ack/err/rty (including one racing the very first issue) is ignored.
    term  = cyc_q & (ack_i | err_i | rty_i) & (cnt_q != '0);
    cnt_d = cnt_q + CNT_W'(issue) - CNT_W'(term);
    // Ready needs a free issue slot this cycle and room for one more transfer
    // after this cycle's issue/termination have been accounted.
    req_ready_o = rstn_i & (~stb_q | ~stall_i) & (cnt_d < MAX_CNT);
    accept      = req_valid_i & req_ready_o;
  end

  // Issue register next state: load on accept, clear after issue, else hold
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    if (accept) begin
      stb_d   = 1'b1;
      we_d    = req_we_i;
      addr_d  = req_addr_i;
      sel_d   = req_sel_i;
      wdata_d = req_wdata_i;
    end else if (issue) begin
      stb_d = 1'b0;
    end
    cyc_d = stb_d | (cnt_d != '0);
  end

  // We-tag FIFO next state: push on issue, pop on termination
  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // When full, a pop and push may share a cycle: the head is read
    // combinationally before the slot is rewritten, so pop effectively goes first.
    if (issue) begin
      tag_d[wr_ptr_q] = we_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (term) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // State registers; everything, including the tag FIFO, clears on reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      cyc_q    <= 1'b0;
      cnt_q    <= '0;
      // NOTE: the tag storage is reset too, so rsp_we_o never shows X or stale tags.
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      cyc_q    <= cyc_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Bus and response outputs
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;
  assign lock_o      = 1'b0;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign sel_o       = sel_q;
  assign wdata_o     = wdata_q;
  assign rsp_valid_o = term;
  assign rsp_we_o    = tag_q[rd_ptr_q];
  assign rsp_rdata_o = rdata_i;
  assign rsp_err_o   = err_i | rty_i;
  assign busy_o      = stb_q | (cnt_q != '0);

endmodule
